// File: rtl/t_toggle_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one bank of WIDTH
// toggle bits: at most one grant per clock, one-hot toggle strobe, held bank state.
module t_toggle_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*IDXW-1:0]   idx,
  output logic [NREQ-1:0]        gnt,
  output logic [WIDTH-1:0]       t_out,
  output logic [WIDTH-1:0]       q,
  output logic                   busy,
  output logic [15:0]            toggle_cnt
);

  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  gnt_r;
  logic [WIDTH-1:0] t_out_r;
  logic [WIDTH-1:0] q_r;
  logic [15:0]      cnt_r;
  logic [PTRW-1:0]  ptr_r;

  logic [NREQ-1:0]  elig;
  logic             found;
  int unsigned      win;
  int unsigned      j;
  logic [IDXW-1:0]  k;
  logic             in_range;
  logic [PTRW-1:0]  ptr_nxt;

  // A requester granted last cycle is masked so a lingering req cannot double-toggle.
  always_comb begin
    elig     = req & ~gnt_r;
    found    = 1'b0;
    win      = 0;
    j        = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      j = (32'(ptr_r) + off) % NREQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        win   = j;
      end
    end
    k        = idx[win*IDXW +: IDXW];
    in_range = (32'(k) < WIDTH);
    ptr_nxt  = PTRW'((win + 1) % NREQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_r   <= '0;
      t_out_r <= '0;
      q_r     <= '0;
      cnt_r   <= '0;
      ptr_r   <= '0;
    end else if (clr) begin
      q_r     <= '0;
      gnt_r   <= '0;
      t_out_r <= '0;
    end else if (en && found) begin
      gnt_r <= NREQ'(1) << win;
      ptr_r <= ptr_nxt;
      // Out-of-range index still consumes the grant but touches nothing else.
      if (in_range) begin
        t_out_r <= WIDTH'(1) << k;
        q_r     <= q_r ^ (WIDTH'(1) << k);
        if (cnt_r != '1) cnt_r <= cnt_r + 16'd1;
      end else begin
        t_out_r <= '0;
      end
    end else begin
      gnt_r   <= '0;
      t_out_r <= '0;
    end
  end

  assign gnt        = gnt_r;
  assign t_out      = t_out_r;
  assign q          = q_r;
  assign toggle_cnt = cnt_r;
  assign busy       = en & (|req);

endmodule

// File: tb/tb_t_toggle_arbiter.sv
// Randomized + directed bench for t_toggle_arbiter: two instances (WIDTH=8 and
// WIDTH=6) driven identically and compared each cycle against a behavioural model.
module tb_t_toggle_arbiter;

  localparam int NREQ = 4;
  localparam int IDXW = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             clr = 1'b0;
  logic [3:0]       req = '0;
  logic [11:0]      idx = '0;

  logic [3:0]  gnt_a, gnt_b;
  logic [7:0]  t_out_a, q_a;
  logic [5:0]  t_out_b, q_b;
  logic        busy_a, busy_b;
  logic [15:0] cnt_a, cnt_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  t_toggle_arbiter #(.NREQ(4), .WIDTH(8), .IDXW(3)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req), .idx(idx),
    .gnt(gnt_a), .t_out(t_out_a), .q(q_a), .busy(busy_a), .toggle_cnt(cnt_a)
  );

  t_toggle_arbiter #(.NREQ(4), .WIDTH(6), .IDXW(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req), .idx(idx),
    .gnt(gnt_b), .t_out(t_out_b), .q(q_b), .busy(busy_b), .toggle_cnt(cnt_b)
  );

  // Behavioural model: instance 0 has 8 bank bits, instance 1 has 6.
  int          m_w[2]   = '{8, 6};
  logic [7:0]  m_q[2]   = '{8'h00, 8'h00};
  logic [7:0]  m_t[2]   = '{8'h00, 8'h00};
  logic [3:0]  m_g[2]   = '{4'h0, 4'h0};
  logic [15:0] m_c[2]   = '{16'h0, 16'h0};
  int          m_p[2]   = '{0, 0};

  always @(posedge clk or posedge rst) begin
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        m_q[n] = '0; m_t[n] = '0; m_g[n] = '0; m_c[n] = '0; m_p[n] = 0;
      end else if (clr) begin
        m_q[n] = '0; m_t[n] = '0; m_g[n] = '0;
      end else begin
        int best, bestd, kk;
        best = -1; bestd = NREQ;
        if (en) begin
          for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !m_g[n][i] && ((i - m_p[n] + NREQ) % NREQ) < bestd) begin
              bestd = (i - m_p[n] + NREQ) % NREQ;
              best  = i;
            end
          end
        end
        if (best >= 0) begin
          m_g[n] = 4'(1 << best);
          m_p[n] = (best + 1) % NREQ;
          kk = int'(idx[best*IDXW +: IDXW]);
          if (kk < m_w[n]) begin
            m_t[n] = 8'(1 << kk);
            m_q[n] = m_q[n] ^ 8'(1 << kk);
            if (m_c[n] != 16'hFFFF) m_c[n] = m_c[n] + 16'd1;
          end else begin
            m_t[n] = '0;
          end
        end else begin
          m_g[n] = '0; m_t[n] = '0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("gnt_a",  32'(gnt_a),   32'(m_g[0]));
      chk("tout_a", 32'(t_out_a), 32'(m_t[0]));
      chk("q_a",    32'(q_a),     32'(m_q[0]));
      chk("cnt_a",  32'(cnt_a),   32'(m_c[0]));
      chk("gnt_b",  32'(gnt_b),   32'(m_g[1]));
      chk("tout_b", 32'(t_out_b), 32'(m_t[1]));
      chk("q_b",    32'(q_b),     32'(m_q[1]));
      chk("cnt_b",  32'(cnt_b),   32'(m_c[1]));
      chk("busy_a", 32'(busy_a),  32'(en && (req != 0)));
      chk("busy_b", 32'(busy_b),  32'(en && (req != 0)));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pack(input int i0, input int i1, input int i2, input int i3);
    return {3'(i3), 3'(i2), 3'(i1), 3'(i0)};
  endfunction

  initial begin
    cyc(2);
    chk("rst_q",   32'(q_a),   32'h0);
    chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_cnt", 32'(cnt_a), 32'h0);
    rst = 1'b0;
    started = 1'b1;
    en = 1'b1;

    // Single toggle, then the same toggle again restores the bit.
    req = 4'b0100; idx = pack(0, 0, 5, 0);
    cyc(1); req = '0;
    chk("single_gnt",  32'(gnt_a),   32'h4);
    chk("single_tout", 32'(t_out_a), 32'h20);
    chk("single_q",    32'(q_a),     32'h20);
    chk("single_cnt",  32'(cnt_a),   32'h1);
    cyc(1);
    req = 4'b0100;
    cyc(1); req = '0;
    chk("again_q",   32'(q_a),   32'h00);
    chk("again_cnt", 32'(cnt_a), 32'h2);
    cyc(1);

    // Pointer at 3: 0 then 1 first, late requester 3 waits its turn.
    idx = pack(0, 1, 2, 3);
    req = 4'b0011; cyc(1); chk("wrap_g0", 32'(gnt_a), 32'h1);
    req = 4'b1010; cyc(1); chk("wrap_g1", 32'(gnt_a), 32'h2);
    req = 4'b1000; cyc(1); chk("wrap_g3", 32'(gnt_a), 32'h8);
    req = '0;
    chk("wrap_q", 32'(q_a), 32'h0B);
    cyc(1);

    // clr holds off a pending request, which is served once clr drops.
    req = 4'b0010; idx = pack(0, 7, 2, 3); clr = 1'b1;
    cyc(1); chk("clr1_q", 32'(q_a), 32'h0); chk("clr1_g", 32'(gnt_a), 32'h0);
    cyc(1); chk("clr2_q", 32'(q_a), 32'h0); chk("clr2_g", 32'(gnt_a), 32'h0);
    clr = 1'b0;
    cyc(1); req = '0;
    chk("clr_gnt",   32'(gnt_a),   32'h2);
    chk("clr_q",     32'(q_a),     32'h80);
    chk("oor_gnt_b", 32'(gnt_b),   32'h2);
    chk("oor_tout_b",32'(t_out_b), 32'h0);
    chk("oor_q_b",   32'(q_b),     32'h0);

    // Asynchronous reset takes effect without a clock edge.
    #2 rst = 1'b1;
    #1;
    chk("arst_q",    32'(q_a),     32'h0);
    chk("arst_gnt",  32'(gnt_a),   32'h0);
    chk("arst_tout", 32'(t_out_a), 32'h0);
    chk("arst_cnt",  32'(cnt_a),   32'h0);
    cyc(1); rst = 1'b0; cyc(1);

    // All requesters continuously requesting: strict rotation.
    req = 4'b1111; idx = pack(0, 1, 2, 3);
    for (int c = 0; c < 8; c++) begin
      cyc(1);
      chk("rr_gnt", 32'(gnt_a), 32'(1 << (c % 4)));
    end
    req = '0;
    chk("rr_q",   32'(q_a),   32'h0);
    chk("rr_cnt", 32'(cnt_a), 32'h8);
    cyc(1);

    en = 1'b0; req = 4'b1111;
    cyc(10);
    chk("dis_gnt", 32'(gnt_a), 32'h0);
    chk("dis_q",   32'(q_a),   32'h0);
    chk("dis_cnt", 32'(cnt_a), 32'h8);

    for (int it = 0; it < 3000; it++) begin
      en  = ($urandom % 8) != 0;
      clr = ($urandom % 16) == 0;
      rst = ($urandom % 200) == 0;
      req = 4'($urandom);
      idx = 12'($urandom);
      cyc(1);
    end
    rst = 1'b0; clr = 1'b0;

    // Long run of in-range toggles drives the counter into saturation.
    en = 1'b1; req = 4'b1111; idx = pack(0, 1, 2, 3);
    cyc(65540);
    chk("sat_cnt_a", 32'(cnt_a), 32'hFFFF);
    chk("sat_cnt_b", 32'(cnt_b), 32'hFFFF);
    req = '0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/t_toggle_arbiter.md
Name: t_toggle_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one bank of WIDTH toggle (T-type) storage bits among NREQ requesters.
- Each requester asks to toggle one bit index. The block grants at most one requester per clock and issues a one-hot toggle strobe to the bank.
- It holds the bank state q, so downstream logic sees a single coherent toggle register.
- It sits between the requesting control blocks and the T-storage datapath and replaces ad-hoc direct toggling.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, number of toggle bits in the bank
- IDXW, 3, index width; must satisfy 2**IDXW >= WIDTH

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- en  input  1  arbitration enable; 0 = no grants issued
- clr  input  1  synchronous clear of bank state
- req  input  NREQ  per-requester toggle request, level, held until granted
- idx  input  NREQ*IDXW  packed bit index per requester; requester i uses idx[i*IDXW +: IDXW]
- gnt  output  NREQ  one-hot grant, 1-cycle pulse
- t_out  output  WIDTH  one-hot toggle strobe to T bank, 1-cycle pulse, coincident with gnt
- q  output  WIDTH  toggle bank state
- busy  output  1  high when any req bit is high and en=1 (combinational)
- toggle_cnt  output  16  count of performed toggles, saturating

Behaviour:
- Reset (async, rst=1): gnt=0, t_out=0, q=0, toggle_cnt=0, round-robin pointer ptr=0. Outputs stay at these values while rst=1. Reset mid-request discards all pending arbitration; requests are re-evaluated from ptr=0 after release.
- Eligibility: req[i] counts only if gnt[i]=0 in the current cycle. This masks a requester that has not yet dropped req, which prevents a double toggle. A requester holding req for 2+ cycles after its gnt is treated as a new request.
- Arbitration is combinational and runs each cycle when en=1 and clr=0. Search starts at ptr and proceeds upward modulo NREQ; the first eligible requester w wins.
- At the rising edge, with winner w and k = idx of w:
  - gnt becomes one-hot w for exactly one cycle.
  - t_out becomes one-hot k.
  - q[k] inverts.
  - ptr becomes (w+1) mod NREQ.
  - toggle_cnt increments unless it equals 0xFFFF (it saturates).
- Latency: request sampled at edge E; gnt, t_out and the updated q are all visible in the cycle after E (1 clock). The fixed arbitration pipeline depth is one register stage; no deeper pipelining.
- Out-of-range index (k >= WIDTH): the grant is still issued and ptr still advances. t_out=0, q is unchanged and toggle_cnt is unchanged (request dropped harmlessly).
- No winner, en=0, or no eligible requester: gnt=0, t_out=0; q, ptr and toggle_cnt hold.
- clr=1 at an edge: q becomes 0, gnt=0, t_out=0, ptr and toggle_cnt hold. clr has priority over arbitration, and no request is lost; pending reqs are served after clr drops.
- Same index from two requesters in consecutive cycles toggles that bit twice, back to its original value; no merging.
- Fairness: with all NREQ requesters continuously re-requesting, each is granted exactly once per NREQ cycles. Worst-case wait for any held request is NREQ-1 grant cycles while en=1.
- busy = en & (|req); ignores masking.

Test Plan:
- Reset/idle: assert rst mid-run with q=8'hA5 -> q=0, gnt=0, t_out=0, toggle_cnt=0 immediately, without waiting for a clock edge; en=0 with req=4'b1111 for 10 cycles -> no gnt and q unchanged.
- Single toggle: req[2]=1, idx2=5 for 1 cycle -> next cycle gnt=4'b0100, t_out=8'h20, q=8'h20, toggle_cnt=1; repeat the same request -> q=8'h00, toggle_cnt=2.
- Round-robin: req=4'b1111 held with idx=0,1,2,3 for 8 cycles -> grants in the order 0,1,2,3,0,1,2,3 and q returns to 8'h00. With requesters continuously re-requesting, no requester is granted twice in consecutive cycles.
- Pointer wrap/skip: ptr=3 and req=4'b0011 -> gnt order 0 then 1; req=4'b1000 arriving during that sequence waits until the pointer reaches it.
- clr vs request: req[1]=1 with idx=7 while clr=1 for 2 cycles -> q=0, no gnt; clr drops -> next cycle gnt=4'b0010, q=8'h80.
- Boundaries: idx=7 with WIDTH=6 -> gnt pulses, t_out=0, q unchanged; preload toggle_cnt to 0xFFFE and issue 3 toggles -> toggle_cnt stays at 0xFFFF.
